// File: rtl/control_carga_fetch.sv
// Program loader and fetch sequencer for the single-cycle core's instruction memory.
// Assembles a byte stream into 32-bit words, writes them, then runs the word-indexed PC.
//
// state   | meaning
// --------+--------------------------------------------------------------
// CARGA   | accepting load bytes, assembling the current word
// ESCRIBE | writing a complete word to instruction memory
// VACIA   | writing a trailing partial word, upper bytes zero
// EJECUTA | run mode, PC sequencing for instruction fetch
module control_carga_fetch #(
    parameter int ANCHO_DIR = 5,
    parameter int PC_INICIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        carga_valido,
    input  logic [7:0]  carga_dato,
    input  logic        carga_fin,
    output logic        carga_listo,
    output logic        we_mem,
    output logic [31:0] dire_mem,
    output logic [31:0] dato_mem,
    input  logic        stall,
    input  logic        salto,
    input  logic [31:0] dire_salto,
    output logic [31:0] pc,
    output logic        run,
    output logic        error_carga
);

    typedef enum logic [1:0] {
        CARGA   = 2'd0,
        ESCRIBE = 2'd1,
        VACIA   = 2'd2,
        EJECUTA = 2'd3
    } estado_t;

    estado_t              estado;
    logic [ANCHO_DIR:0]   ptr_escritura;
    logic [1:0]           cuenta;
    logic [31:0]          ensamblado;
    logic                 fin_pendiente;
    logic [ANCHO_DIR-1:0] pc_q;

    logic                 acepta;
    logic [2:0]           cuenta_sig;
    logic [31:0]          palabra_sig;
    logic                 lleno;
    logic                 unused_salto;

    assign carga_listo  = (estado == CARGA);
    assign acepta       = carga_valido && carga_listo;
    assign cuenta_sig   = {1'b0, cuenta} + {2'b00, acepta};
    assign lleno        = ptr_escritura[ANCHO_DIR];
    assign pc           = {{(32-ANCHO_DIR){1'b0}}, pc_q};
    assign unused_salto = ^dire_salto[31:ANCHO_DIR];

    // A new word starts from zero so a partial flush leaves its upper bytes clear.
    always_comb begin
        palabra_sig = (cuenta == 2'd0) ? 32'd0 : ensamblado;
        if (acepta) begin
            palabra_sig[{cuenta, 3'b000} +: 8] = carga_dato;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= CARGA;
            ptr_escritura <= '0;
            cuenta        <= 2'd0;
            ensamblado    <= 32'd0;
            fin_pendiente <= 1'b0;
            pc_q          <= ANCHO_DIR'(PC_INICIO);
            we_mem        <= 1'b0;
            dire_mem      <= 32'd0;
            dato_mem      <= 32'd0;
            run           <= 1'b0;
            error_carga   <= 1'b0;
        end else begin
            we_mem <= 1'b0;
            case (estado)
                CARGA: begin
                    if (acepta) begin
                        ensamblado <= palabra_sig;
                    end
                    if ((acepta && cuenta == 2'd3) || (carga_fin && cuenta_sig != 3'd0)) begin
                        estado        <= (acepta && cuenta == 2'd3) ? ESCRIBE : VACIA;
                        fin_pendiente <= carga_fin;
                        cuenta        <= 2'd0;
                        dire_mem      <= {{(32-ANCHO_DIR){1'b0}}, ptr_escritura[ANCHO_DIR-1:0]};
                        dato_mem      <= palabra_sig;
                        // Past the last index the word is dropped and the overflow is flagged.
                        if (!lleno) begin
                            we_mem        <= 1'b1;
                            ptr_escritura <= ptr_escritura + 1'b1;
                        end else begin
                            error_carga <= 1'b1;
                        end
                    end else if (carga_fin) begin
                        estado <= EJECUTA;
                        cuenta <= 2'd0;
                    end else begin
                        cuenta <= cuenta_sig[1:0];
                    end
                end
                ESCRIBE: begin
                    estado <= fin_pendiente ? EJECUTA : CARGA;
                end
                VACIA: begin
                    estado <= EJECUTA;
                end
                EJECUTA: begin
                    run <= 1'b1;
                    // The PC leaves PC_INICIO only once run is visible to the core.
                    if (run) begin
                        if (salto) begin
                            pc_q <= dire_salto[ANCHO_DIR-1:0];
                        end else if (!stall) begin
                            pc_q <= pc_q + 1'b1;
                        end
                    end
                end
                default: begin
                    estado <= CARGA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_carga_fetch.sv
// Directed bench for control_carga_fetch: loading, partial flush, overflow,
// PC sequencing and reset recovery, with a write capture on we_mem.
module tb_control_carga_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        carga_valido;
    logic [7:0]  carga_dato;
    logic        carga_fin;
    logic        carga_listo;
    logic        we_mem;
    logic [31:0] dire_mem;
    logic [31:0] dato_mem;
    logic        stall;
    logic        salto;
    logic [31:0] dire_salto;
    logic [31:0] pc;
    logic        run;
    logic        error_carga;

    int checks = 0;
    int failures = 0;
    int ciclo = 0;

    logic [31:0] wr_dir[$];
    logic [31:0] wr_dato[$];
    int          wr_ciclo[$];

    always #5 clk = ~clk;

    control_carga_fetch #(.ANCHO_DIR(5), .PC_INICIO(0)) dut (
        .clk(clk),
        .reset(reset),
        .carga_valido(carga_valido),
        .carga_dato(carga_dato),
        .carga_fin(carga_fin),
        .carga_listo(carga_listo),
        .we_mem(we_mem),
        .dire_mem(dire_mem),
        .dato_mem(dato_mem),
        .stall(stall),
        .salto(salto),
        .dire_salto(dire_salto),
        .pc(pc),
        .run(run),
        .error_carga(error_carga)
    );

    always @(posedge clk) ciclo++;

    always @(negedge clk) begin
        if (we_mem === 1'b1) begin
            wr_dir.push_back(dire_mem);
            wr_dato.push_back(dato_mem);
            wr_ciclo.push_back(ciclo);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_writes;
        wr_dir.delete();
        wr_dato.delete();
        wr_ciclo.delete();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        carga_valido = 1'b0;
        carga_fin = 1'b0;
        stall = 1'b0;
        salto = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        clear_writes;
    endtask

    task automatic wait_listo;
        int n;
        n = 0;
        while (carga_listo !== 1'b1 && n < 10) begin
            tick;
            n++;
        end
        if (carga_listo !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wait_listo: carga_listo=%b after %0d cycles, required 1", carga_listo, n);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fin);
        wait_listo;
        carga_valido = 1'b1;
        carga_dato = b;
        carga_fin = fin;
        tick;
        carga_valido = 1'b0;
        carga_fin = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0], 1'b0);
        send_byte(w[15:8], 1'b0);
        send_byte(w[23:16], 1'b0);
        send_byte(w[31:24], 1'b0);
    endtask

    task automatic send_fin;
        wait_listo;
        carga_fin = 1'b1;
        tick;
        carga_fin = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (carga_listo !== 1'b1) begin failures++; $display("FAIL reset_listo: got %b want 1", carga_listo); end
        checks++; if (we_mem !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", we_mem); end
        checks++; if (dire_mem !== 32'd0) begin failures++; $display("FAIL reset_dire: got %h want 0", dire_mem); end
        checks++; if (dato_mem !== 32'd0) begin failures++; $display("FAIL reset_dato: got %h want 0", dato_mem); end
        checks++; if (pc !== 32'd0) begin failures++; $display("FAIL reset_pc: got %h want 0", pc); end
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL reset_run: got %b want 0", run); end
        checks++; if (error_carga !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", error_carga); end
    endtask

    task automatic test_carga_basica;
        logic [31:0] exp_dato[2];
        exp_dato[0] = 32'h0000_0001;
        exp_dato[1] = 32'h0000_0002;
        do_reset;
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        send_fin;
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL basic_run_early: got %b want 0", run); end
        checks++; if (wr_dir.size() !== 2) begin failures++; $display("FAIL basic_nwrites: got %0d want 2", wr_dir.size()); end
        for (int i = 0; i < 2 && i < wr_dir.size(); i++) begin
            checks++; if (wr_dir[i] !== 32'(i)) begin failures++; $display("FAIL basic_dire%0d: got %h want %h", i, wr_dir[i], i); end
            checks++; if (wr_dato[i] !== exp_dato[i]) begin failures++; $display("FAIL basic_dato%0d: got %h want %h", i, wr_dato[i], exp_dato[i]); end
        end
        tick;
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL basic_run: got %b want 1", run); end
        checks++; if (pc !== 32'd0) begin failures++; $display("FAIL basic_pc0: got %h want 0", pc); end
        tick;
        checks++; if (pc !== 32'd1) begin failures++; $display("FAIL basic_pc1: got %h want 1", pc); end
        tick;
        checks++; if (pc !== 32'd2) begin failures++; $display("FAIL basic_pc2: got %h want 2", pc); end
    endtask

    task automatic test_vacia;
        do_reset;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        checks++; if (we_mem !== 1'b1) begin failures++; $display("FAIL vacia_we: got %b want 1", we_mem); end
        checks++; if (dato_mem !== 32'h0000_BBAA) begin failures++; $display("FAIL vacia_dato: got %h want 0000bbaa", dato_mem); end
        checks++; if (dire_mem !== 32'd0) begin failures++; $display("FAIL vacia_dire: got %h want 0", dire_mem); end
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL vacia_run_n: got %b want 0", run); end
        tick;
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL vacia_run_n1: got %b want 0", run); end
        checks++; if (we_mem !== 1'b0) begin failures++; $display("FAIL vacia_we_off: got %b want 0", we_mem); end
        tick;
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL vacia_run_n2: got %b want 1", run); end
        checks++; if (pc !== 32'd0) begin failures++; $display("FAIL vacia_pc: got %h want 0", pc); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        send_word(32'hDEAD_BEEF);
        send_word(32'h1234_5678);
        tick;
        checks++; if (wr_dir.size() !== 2) begin failures++; $display("FAIL b2b_nwrites: got %0d want 2", wr_dir.size()); end
        if (wr_dir.size() >= 2) begin
            checks++; if (wr_ciclo[1] - wr_ciclo[0] !== 5) begin failures++; $display("FAIL b2b_spacing: got %0d want 5", wr_ciclo[1] - wr_ciclo[0]); end
            checks++; if (wr_dato[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b_dato0: got %h want deadbeef", wr_dato[0]); end
            checks++; if (wr_dato[1] !== 32'h1234_5678) begin failures++; $display("FAIL b2b_dato1: got %h want 12345678", wr_dato[1]); end
            checks++; if (wr_dir[1] !== 32'd1) begin failures++; $display("FAIL b2b_dire1: got %h want 1", wr_dir[1]); end
        end
    endtask

    task automatic test_desborde;
        int malos;
        do_reset;
        for (int k = 0; k < 32; k++) send_word(32'h0000_0100 + 32'(k));
        tick;
        checks++; if (error_carga !== 1'b0) begin failures++; $display("FAIL ovf_error_early: got %b want 0", error_carga); end
        checks++; if (wr_dir.size() !== 32) begin failures++; $display("FAIL ovf_nwrites32: got %0d want 32", wr_dir.size()); end
        send_word(32'hCAFE_F00D);
        checks++; if (we_mem !== 1'b0) begin failures++; $display("FAIL ovf_we_dropped: got %b want 0", we_mem); end
        checks++; if (error_carga !== 1'b1) begin failures++; $display("FAIL ovf_error: got %b want 1", error_carga); end
        tick;
        checks++; if (wr_dir.size() !== 32) begin failures++; $display("FAIL ovf_nwrites: got %0d want 32", wr_dir.size()); end
        malos = 0;
        for (int i = 0; i < wr_dir.size(); i++) begin
            if (wr_dir[i] !== 32'(i) || wr_dato[i] !== 32'h0000_0100 + 32'(i)) malos++;
        end
        checks++; if (malos != 0) begin failures++; $display("FAIL ovf_contents: got %0d bad entries want 0", malos); end
        send_fin;
        tick;
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL ovf_run: got %b want 1", run); end
        checks++; if (error_carga !== 1'b1) begin failures++; $display("FAIL ovf_error_sticky: got %b want 1", error_carga); end
    endtask

    task automatic test_pc;
        salto = 1'b1;
        dire_salto = 32'd31;
        tick;
        salto = 1'b0;
        checks++; if (pc !== 32'd31) begin failures++; $display("FAIL pc_salto31: got %h want 1f", pc); end
        tick;
        checks++; if (pc !== 32'd0) begin failures++; $display("FAIL pc_wrap: got %h want 0", pc); end
        tick;
        checks++; if (pc !== 32'd1) begin failures++; $display("FAIL pc_inc: got %h want 1", pc); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (pc !== 32'd1) begin failures++; $display("FAIL pc_stall%0d: got %h want 1", i, pc); end
        end
        salto = 1'b1;
        dire_salto = 32'h25;
        tick;
        salto = 1'b0;
        stall = 1'b0;
        checks++; if (pc !== 32'd5) begin failures++; $display("FAIL pc_salto_stall: got %h want 5", pc); end
        tick;
        checks++; if (pc !== 32'd6) begin failures++; $display("FAIL pc_after: got %h want 6", pc); end
    endtask

    task automatic test_reset_mitad;
        do_reset;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        clear_writes;
        checks++; if (carga_listo !== 1'b1) begin failures++; $display("FAIL mid_listo: got %b want 1", carga_listo); end
        checks++; if (we_mem !== 1'b0) begin failures++; $display("FAIL mid_we: got %b want 0", we_mem); end
        tick;
        checks++; if (wr_dir.size() !== 0) begin failures++; $display("FAIL mid_nowrite: got %0d want 0", wr_dir.size()); end
        send_word(32'h7766_5544);
        checks++; if (we_mem !== 1'b1) begin failures++; $display("FAIL mid_we_new: got %b want 1", we_mem); end
        checks++; if (carga_listo !== 1'b0) begin failures++; $display("FAIL mid_listo_busy: got %b want 0", carga_listo); end
        checks++; if (dire_mem !== 32'd0) begin failures++; $display("FAIL mid_dire: got %h want 0", dire_mem); end
        checks++; if (dato_mem !== 32'h7766_5544) begin failures++; $display("FAIL mid_dato: got %h want 77665544", dato_mem); end
        // reset lands while the word is being written
        reset = 1'b1;
        tick;
        checks++; if (we_mem !== 1'b0) begin failures++; $display("FAIL wr_reset_we: got %b want 0", we_mem); end
        checks++; if (carga_listo !== 1'b1) begin failures++; $display("FAIL wr_reset_listo: got %b want 1", carga_listo); end
        checks++; if (dato_mem !== 32'd0) begin failures++; $display("FAIL wr_reset_dato: got %h want 0", dato_mem); end
        reset = 1'b0;
    endtask

    task automatic test_reset_ejecuta;
        do_reset;
        send_fin;
        tick;
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL exe_run: got %b want 1", run); end
        salto = 1'b1;
        dire_salto = 32'd7;
        tick;
        salto = 1'b0;
        checks++; if (pc !== 32'd7) begin failures++; $display("FAIL exe_pc7: got %h want 7", pc); end
        reset = 1'b1;
        tick;
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL exe_reset_run: got %b want 0", run); end
        checks++; if (pc !== 32'd0) begin failures++; $display("FAIL exe_reset_pc: got %h want 0", pc); end
        checks++; if (carga_listo !== 1'b1) begin failures++; $display("FAIL exe_reset_listo: got %b want 1", carga_listo); end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        carga_valido = 1'b0;
        carga_dato = 8'h00;
        carga_fin = 1'b0;
        stall = 1'b0;
        salto = 1'b0;
        dire_salto = 32'd0;
        test_reset;
        test_carga_basica;
        test_vacia;
        test_back_to_back;
        test_desborde;
        test_pc;
        test_reset_mitad;
        test_reset_ejecuta;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
